// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives imem_addr and fills the IF/ID register.
// Optional build macro IF_DELAY_SLOT_EN enables MIPS branch-delay-slot redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fetch_fault
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]  state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] ifid_pc_r, ifid_pc_s;
  logic [31:0] ifid_pc4_r, ifid_pc4_s;
  logic        valid_r, valid_s;
  logic        fault_r, fault_s;
  logic [31:0] pc_plus4_s;
  logic        misaligned_s;
`ifdef IF_DELAY_SLOT_EN
  logic        pend_valid_r, pend_valid_s;
  logic [31:0] pend_target_r, pend_target_s;
`endif

  assign imem_addr   = pc_r;
  assign ifid_instr  = instr_r;
  assign ifid_pc     = ifid_pc_r;
  assign ifid_pc4    = ifid_pc4_r;
  assign ifid_valid  = valid_r;
  assign fetch_fault = fault_r;

  // Next-state selection for PC, IF/ID and FSM
  always_comb begin
    pc_plus4_s   = pc_r + 32'd4;
    misaligned_s = (redirect_target[1:0] != 2'b00);
    state_s      = state_r;
    pc_s         = pc_r;
    instr_s      = instr_r;
    ifid_pc_s    = ifid_pc_r;
    ifid_pc4_s   = ifid_pc4_r;
    valid_s      = valid_r;
    fault_s      = fault_r;
`ifdef IF_DELAY_SLOT_EN
    pend_valid_s  = pend_valid_r;
    pend_target_s = pend_target_r;
`endif
    case (state_r)
      BOOT: begin
        state_s = RUN;
      end
      RUN: begin
        if (redirect_valid && misaligned_s) begin
          fault_s = 1'b1;
          state_s = HALT;
          instr_s = NOP_INSTR;
          valid_s = 1'b0;
        end else if (redirect_valid) begin
`ifdef IF_DELAY_SLOT_EN
          // Delay slot: a stalled redirect is parked until the slot can be captured
          if (stall) begin
            pend_valid_s  = 1'b1;
            pend_target_s = redirect_target;
          end else begin
            instr_s      = imem_rdata;
            ifid_pc_s    = pc_r;
            ifid_pc4_s   = pc_plus4_s;
            valid_s      = 1'b1;
            pc_s         = redirect_target;
            pend_valid_s = 1'b0;
          end
`else
          pc_s    = redirect_target;
          instr_s = NOP_INSTR;
          valid_s = 1'b0;
`endif
        end else if (stall) begin
          pc_s = pc_r;
        end else begin
          instr_s    = imem_rdata;
          ifid_pc_s  = pc_r;
          ifid_pc4_s = pc_plus4_s;
          valid_s    = 1'b1;
`ifdef IF_DELAY_SLOT_EN
          if (pend_valid_r) begin
            pc_s         = pend_target_r;
            pend_valid_s = 1'b0;
          end else begin
            pc_s = pc_plus4_s;
          end
`else
          pc_s = pc_plus4_s;
`endif
        end
      end
      HALT: begin
        valid_s = 1'b0;
      end
      default: begin
        state_s = HALT;
        valid_s = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC;
      instr_r    <= NOP_INSTR;
      ifid_pc_r  <= 32'h0000_0000;
      ifid_pc4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
      fault_r    <= 1'b0;
`ifdef IF_DELAY_SLOT_EN
      pend_valid_r  <= 1'b0;
      pend_target_r <= 32'h0000_0000;
`endif
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      instr_r    <= instr_s;
      ifid_pc_r  <= ifid_pc_s;
      ifid_pc4_r <= ifid_pc4_s;
      valid_r    <= valid_s;
      fault_r    <= fault_s;
`ifdef IF_DELAY_SLOT_EN
      pend_valid_r  <= pend_valid_s;
      pend_target_r <= pend_target_s;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan steps plus randomized traffic
// compared against a behavioural fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
  logic        ifid_valid, fetch_fault;

  logic [31:0] imem_addr_w, imem_rdata_w;
  logic [31:0] ifid_instr_w, ifid_pc_w, ifid_pc4_w;
  logic        ifid_valid_w, fetch_fault_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h2008_0005;
    else if (a == 32'h0000_0004) return 32'h2009_0003;
    else return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata   = mem_word(imem_addr);
  assign imem_rdata_w = mem_word(imem_addr_w);

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .fetch_fault(fetch_fault)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_w (
    .clk(clk), .reset(reset), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_target(32'h0000_0000),
    .ifid_instr(ifid_instr_w), .ifid_pc(ifid_pc_w), .ifid_pc4(ifid_pc4_w),
    .ifid_valid(ifid_valid_w), .fetch_fault(fetch_fault_w)
  );

  // Behavioural model: what the fetch stage should be holding after each edge
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_pend_t;
  logic        m_valid, m_fault, m_booted, m_halted, m_pend_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [31:0] next_pc);
    m_instr = mem_word(m_pc);
    m_ipc   = m_pc;
    m_ipc4  = m_pc + 32'd4;
    m_valid = 1'b1;
    m_pc    = next_pc;
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
      m_valid = 1'b0; m_fault = 1'b0; m_booted = 1'b0; m_halted = 1'b0;
      m_pend_v = 1'b0; m_pend_t = 32'h0;
    end else if (!m_booted) begin
      m_booted = 1'b1;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (redirect_valid && (redirect_target % 32'd4 != 32'd0)) begin
      m_fault = 1'b1; m_halted = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
    end else if (redirect_valid) begin
`ifdef IF_DELAY_SLOT_EN
      if (stall) begin
        m_pend_v = 1'b1; m_pend_t = redirect_target;
      end else begin
        capture(redirect_target); m_pend_v = 1'b0;
      end
`else
      m_pc = redirect_target; m_instr = 32'h0; m_valid = 1'b0;
`endif
    end else if (!stall) begin
      if (m_pend_v) begin
        capture(m_pend_t); m_pend_v = 1'b0;
      end else begin
        capture(m_pc + 32'd4);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_pc4", ifid_pc4, m_ipc4);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
  endtask

  task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] t);
    reset = r; stall = s; redirect_valid = rv; redirect_target = t;
  endtask

  logic [31:0] hold_pc, tgt;
  int halted_cycles;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step(); step();
    chk("rst_pc", imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);

    // Reset release and first two fetches
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("boot_valid", {31'd0, ifid_valid}, 32'd0);
    step();
    chk("tp1_instr", ifid_instr, 32'h2008_0005);
    chk("tp1_pc", ifid_pc, 32'h0000_0000);
    chk("tp1_pc4", ifid_pc4, 32'h0000_0004);
    chk("tp1_valid", {31'd0, ifid_valid}, 32'd1);
    chk("wrap_pc", ifid_pc_w, 32'hFFFF_FFFC);
    chk("wrap_pc4", ifid_pc4_w, 32'h0000_0000);
    chk("wrap_addr", imem_addr_w, 32'h0000_0000);
    step();
    chk("tp2_instr", ifid_instr, 32'h2009_0003);
    chk("tp2_pc", ifid_pc, 32'h0000_0004);

    // Three stalled cycles at pc=8
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", imem_addr, 32'h0000_0008);
      chk("stall_ifid_pc", ifid_pc, 32'h0000_0004);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("unstall_addr", imem_addr, 32'h0000_000C);

`ifndef IF_DELAY_SLOT_EN
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    step();
    chk("redir_addr", imem_addr, 32'h0000_0040);
    chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
    chk("redir_instr", ifid_instr, 32'h0000_0000);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("tgt_pc", ifid_pc, 32'h0000_0040);
    chk("tgt_valid", {31'd0, ifid_valid}, 32'd1);
`else
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0010);
    step();
    chk("ds_pc10", imem_addr, 32'h0000_0010);
    hold_pc = ifid_pc;
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0080);
    step();
    chk("ds_hold_pc", ifid_pc, hold_pc);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("ds_slot_pc", ifid_pc, 32'h0000_0010);
    chk("ds_slot_valid", {31'd0, ifid_valid}, 32'd1);
    chk("ds_target", imem_addr, 32'h0000_0080);
`endif

    // Misaligned redirect halts until reset
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0042);
    hold_pc = imem_addr;
    step();
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_pc", imem_addr, hold_pc);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 32'h0000_0100);
      step();
      chk("halt_valid", {31'd0, ifid_valid}, 32'd0);
      chk("halt_pc", imem_addr, hold_pc);
    end
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    step();
    chk("clr_fault", {31'd0, fetch_fault}, 32'd0);
    chk("clr_pc", imem_addr, 32'h0000_0000);

    // Randomized traffic against the model
    halted_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 99) < 3) tgt[1:0] = 2'($urandom_range(1, 3));
      drive(($urandom_range(0, 99) >= 2) && (halted_cycles < 5),
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15, tgt);
      step();
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of decode (Control / Register_File).
- Owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register.
- Supports stall and redirect (branch/jump) from later stages.
- Detects misaligned redirect targets and halts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word placed in ifid_instr on flush/reset (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk; 0 = reset.
- imem_addr  out  32  current PC; combinational from the PC register.
- imem_rdata  in  32  instruction at imem_addr; combinational memory, valid in the same cycle.
- stall  in  1  hazard unit request to hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_target  in  32  new PC when redirect_valid=1.
- ifid_instr  out  32  registered instruction.
- ifid_pc  out  32  registered PC of ifid_instr.
- ifid_pc4  out  32  registered ifid_pc+4.
- ifid_valid  out  1  ifid_instr is a real instruction (0 = bubble).
- fetch_fault  out  1  sticky: a misaligned redirect was seen.

Behaviour:
- Reset (reset=0 at posedge):
  - pc=RESET_PC; ifid_instr=NOP_INSTR; ifid_pc=0; ifid_pc4=0; ifid_valid=0; fetch_fault=0; state=BOOT.
  - Pending-redirect register cleared.
  - Reset wins over every other input, in any state.
- FSM states BOOT, RUN, HALT:
  - BOOT: one cycle; pc held; ifid_valid stays 0. Next state RUN unconditionally; stall and redirect are ignored.
  - RUN: per-cycle priority is misaligned redirect > redirect > stall > normal.
    - Normal: pc<=pc+4; ifid_instr<=imem_rdata; ifid_pc<=pc; ifid_pc4<=pc+4; ifid_valid<=1.
    - Stall only: pc and all ifid_* hold their values.
    - Redirect with redirect_target[1:0]==0: pc<=redirect_target. IF/ID is flushed (ifid_instr<=NOP_INSTR, ifid_valid<=0; ifid_pc/ifid_pc4 hold). Redirect overrides a simultaneous stall.
    - Redirect with redirect_target[1:0]!=0: fetch_fault<=1; state<=HALT; pc unchanged; IF/ID flushed.
  - HALT: pc and ifid_* hold; ifid_valid=0; all inputs ignored; exit only by reset.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Latency: the first valid instruction (at RESET_PC) appears on ifid_* at the 2nd posedge after reset is released. After that, throughput is one instruction per unstalled cycle.
- Redirect penalty without delay slots: 1 bubble. The target instruction is in IF/ID 2 cycles after redirect_valid.
- imem_addr always equals pc; it is never X after reset.

Optional Feature:
- Macro: IF_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - A redirect in RUN does not flush. The word at the current pc is captured into IF/ID as in the normal case (ifid_valid<=1), and pc<=redirect_target.
  - If stall=1 in the same cycle, the target is stored in the pending register and IF/ID holds.
  - At the first cycle with stall=0, the delay slot is captured and pc<=pending target; pending is then cleared.
  - A new redirect while pending is set replaces the pending target.
  - Misaligned detection applies at capture time of the redirect.
- Undefined: behaviour exactly as in RUN above; no pending register is synthesized.

Test Plan:
- Reset release, RESET_PC=0, imem returns 32'h2008_0005 at 0 and 32'h2009_0003 at 4 → posedge 2: ifid_instr=2008_0005, ifid_pc=0, ifid_pc4=4, valid=1; posedge 3: ifid_instr=2009_0003, ifid_pc=4.
- stall=1 for 3 cycles with pc=8 → imem_addr stays 8 and ifid_* unchanged for those 3 cycles; first cycle after release: pc=12.
- redirect_valid=1, target=32'h40, stall=1, macro undefined → next cycle pc=0x40, ifid_valid=0, ifid_instr=NOP_INSTR; following cycle ifid_pc=0x40, valid=1.
- redirect target=32'h42 → fetch_fault=1 next cycle, pc frozen, ifid_valid=0 permanently; reset=0 for one posedge → fetch_fault=0, pc=RESET_PC.
- RESET_PC=32'hFFFF_FFFC, run 2 unstalled cycles → ifid_pc=FFFF_FFFC, ifid_pc4=0, next imem_addr=0.
- IF_DELAY_SLOT_EN, pc=0x10, redirect to 0x80 with stall=1, then stall=0 → IF/ID holds while stalled; on release ifid_pc=0x10, valid=1, pc=0x80.
